store_narrow_rmw: RTL and testbench
===================================

STORE_NARROW_RMW -- requirements
Module: store_narrow_rmw

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the maximum number of cycles to wait for mem_ack in one memory phase.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  single-cycle request to perform one store; sampled only in IDLE.
REQ-005 store_type  input  2  00=sw, 01=sh, 10=sb, 11=illegal.
REQ-006 addr  input  32  byte address of the store.
REQ-007 wdata  input  32  store data, right-justified for sh/sb.
REQ-008 busy  output  1  high from the cycle after an accepted start until done.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 misaligned  output  1  error qualifier, valid only with done.
REQ-011 timeout  output  1  error qualifier, valid only with done.
REQ-012 mem_req  output  1  memory request; held high until mem_ack.
REQ-013 mem_we  output  1  1=write, 0=read; valid while mem_req is high.
REQ-014 mem_addr  output  32  word address {addr[31:2],2'b00}.
REQ-015 mem_wdata  output  32  full word to write.
REQ-016 mem_ack  input  1  one-cycle acknowledge; ignored while mem_req is low.
REQ-017 mem_rdata  input  32  read data, valid with mem_ack when mem_we is 0.

Function
REQ-018 The FSM SHALL have the states IDLE, READ, WRITE and DONE.
REQ-019 In IDLE, start=1 SHALL latch store_type, addr and wdata; the next state is chosen per REQ-020 to REQ-022.
REQ-020 A misaligned store SHALL go to DONE with misaligned=1 and SHALL issue no memory access; misaligned means sw with addr[1:0]!=0, sh with addr[0]!=0, or store_type 11.
REQ-021 An aligned sw SHALL go directly to WRITE, with mem_wdata equal to the latched wdata.
REQ-022 An aligned sh or sb SHALL go to READ.
REQ-023 READ SHALL drive mem_req=1 and mem_we=0; on mem_ack it SHALL capture mem_rdata, form the merged word and go to WRITE.
REQ-024 The merge is little-endian.
  - sb: byte lane k=addr[1:0], bits [8k+7:8k], replaced by wdata[7:0].
  - sh: half lane addr[1] replaced by wdata[15:0].
  - All other bits keep mem_rdata.
REQ-025 WRITE SHALL drive mem_req=1 and mem_we=1; on mem_ack it SHALL go to DONE.
REQ-026 mem_req SHALL drop to 0 in the cycle after the mem_ack that ends a phase; it SHALL not be held continuously from READ into WRITE.
REQ-027 DONE SHALL assert done=1 for exactly one cycle, with the error flags, then return to IDLE.
REQ-028 A cycle counter SHALL clear on entry to READ or WRITE; if TIMEOUT cycles elapse without mem_ack, the FSM SHALL drop mem_req and go to DONE with timeout=1.
REQ-029 start SHALL be ignored outside IDLE, including during DONE.
REQ-030 All outputs SHALL be registered.
REQ-031 Latency, with start at cycle 0 and ack in the first cycle of each phase:
  - sw: mem_req at cycle 1, done at cycle 3.
  - sh/sb: read at cycle 1, write at cycle 3, done at cycle 5.
  - Misaligned: done at cycle 2.

Reset
REQ-032 rst=1 SHALL force IDLE and zero busy, done, misaligned, timeout, mem_req, mem_we, mem_addr, mem_wdata and the counter on the same edge.
REQ-033 rst asserted mid-operation SHALL abandon the access without a done pulse; a late mem_ack after reset SHALL be ignored.

Structure
REQ-034 The store_type encodings, the state encoding and the TIMEOUT default SHALL live in the shared package mips_mem_pkg.
REQ-035 The lane merge SHALL be the combinational sub-module byte_lane_merge (inputs: old word, new data, type, addr[1:0]; output: word).

Verification
REQ-036 sw, addr=0x100, wdata=0xDEADBEEF, immediate ack -> one write to 0x100 of 0xDEADBEEF; done at cycle 3; no read.
REQ-037 sb, addr=0x203, wdata=0x000000AB, rdata=0x11223344 -> read then write to 0x200 of 0xAB223344; done at cycle 5.
REQ-038 sh, addr=0x302, wdata=0x0000CAFE, rdata=0x11223344 -> write of 0xCAFE3344.
REQ-039 sh, addr=0x101 -> done at cycle 2 with misaligned=1; mem_req never asserted.
REQ-040 sw with mem_ack withheld and TIMEOUT=16 -> mem_req drops after 16 cycles; done with timeout=1.
REQ-041 rst pulsed during READ of an sb, then a second start pulsed during busy -> no done, all outputs 0; the start during busy is ignored.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the narrow-store read-modify-write unit.
// Store types, FSM state codes and the default ack timeout.
package mips_mem_pkg;

   localparam logic [1:0] ST_SW  = 2'b00;
   localparam logic [1:0] ST_SH  = 2'b01;
   localparam logic [1:0] ST_SB  = 2'b10;
   localparam logic [1:0] ST_BAD = 2'b11;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam int TIMEOUT_DEF = 16;

   function automatic logic is_misaligned(
      input logic [1:0] t,
      input logic [1:0] a
   );
      return (t == ST_BAD)
          || (t == ST_SW && a != 2'b00)
          || (t == ST_SH && a[0]);
   endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Little-endian lane merge of store data into an old memory word.
// sb replaces one byte lane, sh one half lane, sw the whole word.
module byte_lane_merge
   import mips_mem_pkg::*;
(
   input  logic [31:0] old,
   input  logic [31:0] data,
   input  logic [1:0]  stype,
   input  logic [1:0]  off,
   output logic [31:0] word
);

   always_comb begin
      word = old;
      unique case (1'b1)
         stype == ST_SB: word[{off, 3'b000} +: 8]         = data[7:0];
         stype == ST_SH: word[{off[1], 4'b0000} +: 16]    = data[15:0];
         stype == ST_SW: word                             = data;
         default: ;
      endcase
   end

endmodule

// File: rtl/store_narrow_rmw.sv
// Store unit: sw writes directly, sh/sb do read-merge-write.
// Misaligned stores finish without touching memory.
module store_narrow_rmw
   import mips_mem_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  store_type,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        misaligned,
   output logic        timeout,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);

   logic [1:0]    state;
   logic [1:0]    stype_r;
   logic [1:0]    off_r;
   logic [31:0]   wdata_r;
   logic          mis_r;
   logic          to_r;
   logic [CW-1:0] cnt;
   logic [31:0]   merged;

   byte_lane_merge u_merge (
      .old   (mem_rdata),
      .data  (wdata_r),
      .stype (stype_r),
      .off   (off_r),
      .word  (merged)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         stype_r    <= ST_SW;
         off_r      <= 2'b00;
         wdata_r    <= '0;
         mis_r      <= 1'b0;
         to_r       <= 1'b0;
         cnt        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         misaligned <= 1'b0;
         timeout    <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               done       <= 1'b0;
               misaligned <= 1'b0;
               timeout    <= 1'b0;
               if (start) begin
                  stype_r <= store_type;
                  off_r   <= addr[1:0];
                  wdata_r <= wdata;
                  busy    <= 1'b1;
                  cnt     <= '0;
                  to_r    <= 1'b0;
                  mis_r   <= is_misaligned(store_type, addr[1:0]);
                  if (is_misaligned(store_type, addr[1:0])) begin
                     state <= S_DONE;
                  end else if (store_type == ST_SW) begin
                     mem_addr  <= {addr[31:2], 2'b00};
                     mem_wdata <= wdata;
                     mem_req   <= 1'b1;
                     mem_we    <= 1'b1;
                     state     <= S_WRITE;
                  end else begin
                     mem_addr <= {addr[31:2], 2'b00};
                     mem_req  <= 1'b1;
                     mem_we   <= 1'b0;
                     state    <= S_READ;
                  end
               end
            end
            S_READ: begin
               if (mem_ack) begin
                  mem_wdata <= merged;
                  mem_req   <= 1'b0;
                  cnt       <= '0;
                  state     <= S_WRITE;
               end else if (cnt == LIM) begin
                  mem_req <= 1'b0;
                  to_r    <= 1'b1;
                  state   <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_WRITE: begin
               // coming from READ, req idles one cycle before the write
               if (!mem_req) begin
                  mem_req <= 1'b1;
                  mem_we  <= 1'b1;
                  cnt     <= '0;
               end else if (mem_ack) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  state   <= S_DONE;
               end else if (cnt == LIM) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  to_r    <= 1'b1;
                  state   <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               done       <= 1'b1;
               misaligned <= mis_r;
               timeout    <= to_r;
               busy       <= 1'b0;
               mem_we     <= 1'b0;
               state      <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Bench for store_narrow_rmw: memory responder plus a byte-level
// model of store semantics, directed cases then random stores.
module tb_store_narrow_rmw;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  store_type;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        misaligned;
   logic        timeout;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   store_narrow_rmw #(.TIMEOUT(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .store_type (store_type),
      .addr       (addr),
      .wdata      (wdata),
      .busy       (busy),
      .done       (done),
      .misaligned (misaligned),
      .timeout    (timeout),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] mem [logic [31:0]];

   function automatic logic [31:0] memrd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a * 32'h9E37_79B1;
   endfunction

   // bytes covered by a store of size n start at the n-aligned offset
   function automatic logic [31:0] exp_word(input logic [1:0] t,
         input logic [31:0] a, input logic [31:0] w,
         input logic [31:0] old);
      logic [31:0] r;
      int n;
      int base;
      r = old;
      n = (t == 2'd0) ? 4 : (t == 2'd1) ? 2 : 1;
      base = (int'(a % 4) / n) * n;
      for (int i = 0; i < n; i++) r[8*(base+i) +: 8] = w[8*i +: 8];
      return r;
   endfunction

   function automatic bit exp_mis(input logic [1:0] t,
         input logic [31:0] a);
      int n;
      n = (t == 2'd0) ? 4 : (t == 2'd1) ? 2 : 1;
      return (t == 2'd3) || ((a % n) != 0);
   endfunction

   int ack_delay = 0;
   bit resp_en = 1'b1;
   int wait_cnt = 0;
   int reqcyc = 0;
   int nrd = 0;
   int nwr = 0;
   logic [31:0] last_wa = '0;
   logic [31:0] last_wd = '0;

   initial begin
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (mem_req) reqcyc++;
         if (resp_en) begin
            mem_ack = 1'b0;
            if (mem_req) begin
               if (wait_cnt >= ack_delay) begin
                  mem_ack = 1'b1;
                  wait_cnt = 0;
                  if (mem_we) begin
                     nwr++;
                     last_wa = mem_addr;
                     last_wd = mem_wdata;
                     mem[mem_addr] = mem_wdata;
                  end else begin
                     nrd++;
                     mem_rdata = memrd(mem_addr);
                  end
               end else begin
                  wait_cnt++;
               end
            end else begin
               wait_cnt = 0;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
         input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic op(input logic [1:0] t, input logic [31:0] a,
         input logic [31:0] w, input int d, input bit poke);
      logic [31:0] wa;
      logic [31:0] old;
      bit m;
      bit tmo;
      int c0;
      int lat;
      logic b1;
      logic mis_o;
      logic to_o;
      wa = {a[31:2], 2'b00};
      old = memrd(wa);
      m = exp_mis(t, a);
      tmo = !m && d >= 16;
      @(negedge clk);
      store_type = t;
      addr = a;
      wdata = w;
      start = 1'b1;
      ack_delay = d;
      reqcyc = 0;
      nrd = 0;
      nwr = 0;
      c0 = cyc;
      @(negedge clk);
      b1 = busy;
      start = poke;
      store_type = 2'd0;
      addr = 32'h500;
      @(negedge clk);
      start = 1'b0;
      while (!done && (cyc - c0) < 100) @(negedge clk);
      chk("done_seen", 32'(done), 32'd1);
      lat = cyc - c0;
      mis_o = misaligned;
      to_o = timeout;
      chk("busy_c1", 32'(b1), 32'd1);
      chk("misaligned", 32'(mis_o), 32'(m));
      chk("timeout", 32'(to_o), 32'(tmo));
      if (m) begin
         chk("lat_mis", 32'(lat), 32'd2);
         chk("req_mis", 32'(reqcyc), 32'd0);
      end else if (tmo) begin
         chk("lat_to", 32'(lat), 32'd18);
         chk("req_to", 32'(reqcyc), 32'd16);
         chk("wr_to", 32'(nwr), 32'd0);
      end else if (t == 2'd0) begin
         chk("lat_sw", 32'(lat), 32'(3 + d));
         chk("req_sw", 32'(reqcyc), 32'(1 + d));
         chk("rd_sw", 32'(nrd), 32'd0);
         chk("wr_sw", 32'(nwr), 32'd1);
      end else begin
         chk("lat_nar", 32'(lat), 32'(5 + 2*d));
         chk("req_nar", 32'(reqcyc), 32'(2 + 2*d));
         chk("rd_nar", 32'(nrd), 32'd1);
         chk("wr_nar", 32'(nwr), 32'd1);
      end
      if (!m && !tmo) begin
         chk("waddr", last_wa, wa);
         chk("wword", memrd(wa), exp_word(t, a, w, old));
      end
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'd0);
      chk("busy_after", 32'(busy), 32'd0);
      if (poke) begin
         repeat (3) @(negedge clk);
         chk("poke_req", 32'(reqcyc), 32'd0);
         chk("poke_busy", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      logic [31:0] acc;
      rst = 1'b1;
      start = 1'b0;
      store_type = '0;
      addr = '0;
      wdata = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_maddr", mem_addr, 32'd0);
      chk("rst_mwdata", mem_wdata, 32'd0);

      op(2'd0, 32'h100, 32'hDEADBEEF, 0, 1'b0);
      chk("sw_data", last_wd, 32'hDEADBEEF);
      mem[32'h200] = 32'h11223344;
      op(2'd2, 32'h203, 32'h000000AB, 0, 1'b0);
      chk("sb_data", last_wd, 32'hAB223344);
      mem[32'h300] = 32'h11223344;
      op(2'd1, 32'h302, 32'h0000CAFE, 0, 1'b0);
      chk("sh_data", last_wd, 32'hCAFE3344);
      op(2'd1, 32'h101, 32'h12345678, 0, 1'b1);
      op(2'd3, 32'h104, 32'h12345678, 0, 1'b0);
      op(2'd0, 32'h600, 32'h0BADF00D, 1000, 1'b0);
      op(2'd2, 32'h601, 32'h000000EE, 1000, 1'b0);
      op(2'd1, 32'h702, 32'h0000BEEF, 2, 1'b0);

      // reset in the middle of an sb read, with a stray start first
      ack_delay = 1000;
      @(negedge clk);
      store_type = 2'd2;
      addr = 32'h203;
      wdata = 32'h55;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("rd_req", 32'(mem_req), 32'd1);
      chk("rd_we", 32'(mem_we), 32'd0);
      store_type = 2'd0;
      addr = 32'h400;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_start_addr", mem_addr, 32'h200);
      chk("busy_start_we", 32'(mem_we), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_req", 32'(mem_req), 32'd0);
      chk("mid_maddr", mem_addr, 32'd0);
      chk("mid_mwdata", mem_wdata, 32'd0);
      chk("mid_flags", {29'd0, done, misaligned, timeout}, 32'd0);
      resp_en = 1'b0;
      mem_ack = 1'b1;
      reqcyc = 0;
      acc = '0;
      @(negedge clk);
      mem_ack = 1'b0;
      resp_en = 1'b1;
      repeat (6) begin
         acc = acc | {28'd0, done, busy, mem_req, mem_we};
         @(negedge clk);
      end
      chk("late_ack", acc, 32'd0);
      chk("late_req", 32'(reqcyc), 32'd0);

      for (int i = 0; i < 24; i++) begin
         op(2'($urandom_range(0, 3)), 32'h1000 + $urandom_range(0, 63),
            $urandom, $urandom_range(0, 3), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
